key_expansion: RTL and testbench

Iterative AES-128 key schedule that turns a 128-bit cipher key into the 11 round keys (rk0..rk10) and streams them out one per cycle over a valid/ready handshake. It sits directly upstream of the round datapath and supplies the `key` operand each round stage XORs after MixColumns. It also supplies the rk0 key for the initial AddRoundKey and rk10 for the final round. Round keys are generated on the fly, one per cycle, so no 11-entry key store is needed.

---
 rtl/key_expansion.sv | 78 +++++++
 tb/tb_key_expansion.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// key_expansion: iterative AES-128 key schedule streaming rk0..rk10 over valid/ready
module key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [7:0] sbox [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  state_t       state;
  logic [7:0]   rcon;
  logic [31:0]  rot, t, w0, w1, w2, w3;
  logic [127:0] next_key;
  // next round key: SubWord(RotWord(w3)) ^ rcon feeds a 4-word XOR chain
  always_comb begin
    rot = {round_key[23:0], round_key[31:24]};
    t = {sbox[rot[31:24]] ^ rcon, sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]};
    w0 = round_key[127:96] ^ t;
    w1 = round_key[95:64] ^ w0;
    w2 = round_key[63:32] ^ w1;
    w3 = round_key[31:0] ^ w2;
    next_key = {w0, w1, w2, w3};
  end
  assign done = rk_valid & rk_ready & (rk_idx == 4'd10);
  // IDLE/EMIT sequencer; a round key advances only on an accepted transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      round_key <= '0;
      rk_idx <= '0;
      rcon <= 8'h01;
      rk_valid <= 1'b0;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= EMIT;
        round_key <= key;
        rk_idx <= '0;
        rcon <= 8'h01;
        rk_valid <= 1'b1;
        busy <= 1'b1;
      end
    end else if (rk_valid && rk_ready) begin
      if (rk_idx == 4'd10) begin
        state <= IDLE;
        rk_valid <= 1'b0;
        busy <= 1'b0;
      end else begin
        round_key <= next_key;
        rk_idx <= rk_idx + 4'd1;
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: directed checks of the AES-128 key schedule streamer
module tb_key_expansion;
  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [127:0] key;
  logic [127:0] round_key;
  logic [3:0]   rk_idx;
  logic         rk_valid, busy, done;
  int           passed = 0;
  int           total = 0;
  logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] alt_key  = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  always #5 clk = ~clk;
  key_expansion dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .rk_ready(rk_ready),
    .round_key(round_key), .rk_idx(rk_idx), .rk_valid(rk_valid), .busy(busy), .done(done)
  );
  task automatic pulse_start(input logic [127:0] k);
    @(negedge clk);
    start = 1'b1;
    key = k;
    @(negedge clk);
    start = 1'b0;
    key = '0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({round_key, rk_idx, rk_valid, busy, done} !== '0)
      $display("FAIL reset_outputs got rk=%h idx=%0d v=%b b=%b d=%b want all zero", round_key, rk_idx, rk_valid, busy, done);
    else passed++;
    rst = 1'b0;
  endtask
  task automatic test_fips;
    rk_ready = 1'b1;
    pulse_start(fips_key);
    for (int k = 0; k <= 10; k++) begin
      total++;
      if (round_key !== fips_rk[k] || rk_idx !== 4'(k) || rk_valid !== 1'b1 || busy !== 1'b1 || done !== (k == 10))
        $display("FAIL fips_rk%0d got %h idx=%0d v=%b b=%b d=%b want %h", k, round_key, rk_idx, rk_valid, busy, done, fips_rk[k]);
      else passed++;
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL fips_end got b=%b v=%b d=%b want 0 0 0", busy, rk_valid, done);
    else passed++;
  endtask
  task automatic test_zero_key;
    rk_ready = 1'b1;
    pulse_start('0);
    for (int k = 0; k <= 10; k++) begin
      total++;
      if (rk_idx !== 4'(k) || done !== (k == 10))
        $display("FAIL zero_idx%0d got idx=%0d d=%b want idx=%0d", k, rk_idx, done, k);
      else passed++;
      if (k == 0 || k == 1 || k == 10) begin
        total++;
        if (round_key !== (k == 0 ? 128'h0 : k == 1 ? 128'h62636363626363636263636362636363 : 128'hb4ef5bcb3e92e21123e951cf6f8f188e))
          $display("FAIL zero_rk%0d got %h", k, round_key);
        else passed++;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_backpressure;
    int k;
    rk_ready = 1'b1;
    pulse_start(fips_key);
    for (int c = 1; c <= 14; c++) begin
      k = c <= 5 ? c - 1 : c <= 8 ? 4 : c - 4;
      total++;
      if (round_key !== fips_rk[k] || rk_idx !== 4'(k) || rk_valid !== 1'b1 || done !== (c == 14))
        $display("FAIL bp_cycle%0d got %h idx=%0d v=%b d=%b want %h idx=%0d", c, round_key, rk_idx, rk_valid, done, fips_rk[k], k);
      else passed++;
      rk_ready = !(c >= 5 && c <= 7);
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || rk_valid !== 1'b0)
      $display("FAIL bp_end got b=%b v=%b want 0 0", busy, rk_valid);
    else passed++;
  endtask
  task automatic test_ignore_start;
    bit drained = 0;
    rk_ready = 1'b1;
    pulse_start(fips_key);
    for (int k = 0; k <= 10; k++) begin
      total++;
      if (round_key !== fips_rk[k] || rk_idx !== 4'(k) || busy !== 1'b1 || done !== (k == 10))
        $display("FAIL ign_rk%0d got %h idx=%0d b=%b d=%b want %h", k, round_key, rk_idx, busy, done, fips_rk[k]);
      else passed++;
      start = (k == 3 || k == 10);
      key = alt_key;
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || rk_valid !== 1'b0)
      $display("FAIL ign_rk10_start got b=%b v=%b want 0 0", busy, rk_valid);
    else passed++;
    start = 1'b1;
    key = alt_key;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (round_key !== alt_key || rk_idx !== 4'd0 || rk_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL restart got %h idx=%0d v=%b b=%b want %h idx=0 v=1 b=1", round_key, rk_idx, rk_valid, busy, alt_key);
    else passed++;
    for (int c = 0; c < 20 && !drained; c++) begin
      @(negedge clk);
      drained = !busy;
    end
    total++;
    if (!drained) $display("FAIL restart_drain timeout got busy=%b want 0", busy);
    else passed++;
  endtask
  task automatic test_mid_reset;
    rk_ready = 1'b1;
    pulse_start(fips_key);
    for (int k = 0; k <= 6; k++) begin
      total++;
      if (round_key !== fips_rk[k] || rk_idx !== 4'(k))
        $display("FAIL rst_pre_rk%0d got %h idx=%0d want %h", k, round_key, rk_idx, fips_rk[k]);
      else passed++;
      if (k < 6) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({round_key, rk_idx, rk_valid, busy, done} !== '0)
      $display("FAIL mid_reset got rk=%h idx=%0d v=%b b=%b d=%b want all zero", round_key, rk_idx, rk_valid, busy, done);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL post_reset_idle got d=%b b=%b want 0 0", done, busy);
    else passed++;
    start = 1'b1;
    key = fips_key;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      total++;
      if (round_key !== fips_rk[k] || rk_idx !== 4'(k) || done !== (k == 10))
        $display("FAIL rst_post_rk%0d got %h idx=%0d d=%b want %h", k, round_key, rk_idx, done, fips_rk[k]);
      else passed++;
      @(negedge clk);
    end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    rk_ready = 1'b0;
    key = '0;
    test_reset;
    test_fips;
    test_zero_key;
    test_backpressure;
    test_ignore_start;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
